alu_wb_stage: RTL and testbench

//  Registered writeback stage directly downstream of alu_128bit.
//  - Captures result + c/z/o/s flags of each completed ALU op in a 2-entry buffer.
//  - Maintains the architectural flag register; its carry feeds subwb/addinc.
//  - Presents register-file write requests over a valid/ready handshake.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_wb_stage_if.sv | 28 ++
 rtl/wb_skid_fifo.sv | 74 +++++++
 rtl/alu_wb_stage.sv | 74 +++++++
 tb/tb_alu_wb_stage.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, flag bit positions and the
// writeback entry record used by the ALU writeback stage.
package alu_pkg;

    localparam int unsigned ALU_DWIDTH = 32;
    localparam int unsigned ALU_RAW    = 5;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUBWB,
        OP_MOV,
        OP_SUB,
        OP_INC,
        OP_DEC,
        OP_ADDINC,
        OP_LAND,
        OP_LOR,
        OP_LXOR,
        OP_LNOT,
        OP_LSHL
    } optype_e;

    // Bit positions inside the {c,z,o,s} flag nibble.
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_O = 1;
    localparam int unsigned FLAG_S = 0;

    typedef struct packed {
        logic [ALU_RAW-1:0]    addr;
        logic [ALU_DWIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/alu_wb_stage_if.sv
// Handshake bundle between the ALU, the writeback stage and the register file.
// master = surrounding environment (ALU + register file), slave = the stage.
interface alu_wb_stage_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned RAW    = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] in_result;
    logic [3:0]        in_flags;
    logic [RAW-1:0]    in_rd;
    logic              in_we;
    logic              in_flag_we;
    logic              wb_valid;
    logic              wb_ready;
    logic [RAW-1:0]    wb_addr;
    logic [DWIDTH-1:0] wb_data;

    modport master (
        output in_valid, in_result, in_flags, in_rd, in_we, in_flag_we, wb_ready,
        input  in_ready, wb_valid, wb_addr, wb_data
    );

    modport slave (
        input  in_valid, in_result, in_flags, in_rd, in_we, in_flag_we, wb_ready,
        output in_ready, wb_valid, wb_addr, wb_data
    );
endinterface

// File: rtl/wb_skid_fifo.sv
// Two-entry FIFO holding pending register-file writes. Occupancy is tracked
// as a small state machine; 1-bit read/write pointers wrap naturally.
module wb_skid_fifo
    import alu_pkg::*;
#(
    parameter type         T     = wb_entry_t,
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  T           entry_i,
    input  logic       pop_i,
    output logic       ready_o,
    output logic       valid_o,
    output T           head_o,
    output logic [1:0] count_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e state_q, state_d;
    logic wr_q, wr_d;
    logic rd_q, rd_d;
    T     mem_q [2];
    logic push;
    logic pop;

    assign count_o = state_q;
    assign ready_o = (count_o != 2'(DEPTH));
    assign valid_o = (state_q != EMPTY);
    assign head_o  = mem_q[rd_q];
    assign push    = push_i & ready_o;
    assign pop     = pop_i & valid_o;

    // Next occupancy and pointer advance from this cycle's push/pop.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (push) wr_d = ~wr_q;
        if (pop)  rd_d = ~rd_q;
        case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // State, pointers and storage; the head slot is never written while it
    // is still pending, so the presented entry stays stable under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            if (push) mem_q[wr_q] <= entry_i;
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// Registered writeback stage behind alu_128bit: buffers result writes,
// keeps the architectural flag register and the sticky overflow bit.
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int unsigned DWIDTH = ALU_DWIDTH,
    parameter int unsigned RAW    = ALU_RAW,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    alu_wb_stage_if.slave     bus,
    output logic [3:0]        flags,
    output logic              sticky_o,
    input  logic              clr_sticky,
    output logic [1:0]        count
);

    typedef struct packed {
        logic [RAW-1:0]    addr;
        logic [DWIDTH-1:0] data;
    } entry_t;

    logic       accept;
    entry_t     entry_in;
    entry_t     head;
    logic [3:0] flags_q, flags_d;
    logic       sticky_q, sticky_d;

    assign accept   = bus.in_valid & bus.in_ready;
    assign entry_in = '{addr: bus.in_rd, data: bus.in_result};

    // Ops with in_we=0 are consumed here and never occupy a buffer slot.
    wb_skid_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept & bus.in_we),
        .entry_i (entry_in),
        .pop_i   (bus.wb_ready),
        .ready_o (bus.in_ready),
        .valid_o (bus.wb_valid),
        .head_o  (head),
        .count_o (count)
    );

    assign bus.wb_addr = head.addr;
    assign bus.wb_data = head.data;
    assign flags       = flags_q;
    assign sticky_o    = sticky_q;

    // Flag and sticky next state; a new overflow beats a same-cycle clear.
    always_comb begin
        flags_d  = flags_q;
        sticky_d = sticky_q;
        if (accept && bus.in_flag_we) flags_d = bus.in_flags;
        if (accept && bus.in_flag_we && bus.in_flags[FLAG_O]) sticky_d = 1'b1;
        else if (clr_sticky)                                   sticky_d = 1'b0;
    end

    // Architectural flag register and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
        end
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: expected writes queued at accept,
// compared when the register file takes the head entry.
module tb_alu_wb_stage;
    import alu_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_sticky = 1'b0;
    logic [3:0] flags;
    logic       sticky_o;
    logic [1:0] count;

    alu_wb_stage_if #(.DWIDTH(DW), .RAW(RW)) bus ();

    alu_wb_stage #(.DWIDTH(DW), .RAW(RW), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .flags      (flags),
        .sticky_o   (sticky_o),
        .clr_sticky (clr_sticky),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t        sb [$];
    exp_t        mon_e;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Register-file side: every transfer must match the oldest queued write.
    always @(negedge clk) begin
        if (!rst && bus.wb_valid && bus.wb_ready) begin
            check("wb_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("wb_addr", 64'(bus.wb_addr), 64'(mon_e.addr));
                check("wb_data", 64'(bus.wb_data), 64'(mon_e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_op(input logic [RW-1:0] rd, input logic [DW-1:0] d,
                             input logic [3:0] fl, input logic we, input logic fwe,
                             input string tag);
        bit ok;
        ok = 1'b0;
        bus.in_rd      = rd;
        bus.in_result  = d;
        bus.in_flags   = fl;
        bus.in_we      = we;
        bus.in_flag_we = fwe;
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                if (we) sb.push_back('{addr: rd, data: d});
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check({tag, "_accepted"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 40 && count != 2'd0; i++) tick();
        tick();
        check({tag, "_drain_count"}, 64'(count), 64'd0);
        check({tag, "_drain_sb"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_result  = '0;
        bus.in_flags   = '0;
        bus.in_rd      = '0;
        bus.in_we      = 1'b0;
        bus.in_flag_we = 1'b0;
        bus.wb_ready   = 1'b0;

        // Power-on reset values
        repeat (2) tick();
        check("rst_count", 64'(count), 64'd0);
        check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        check("rst_wb_addr", 64'(bus.wb_addr), 64'd0);
        check("rst_wb_data", 64'(bus.wb_data), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_sticky", 64'(sticky_o), 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Single op, visible one cycle after accept
        bus.wb_ready = 1'b0;
        accept_op(5'd5, 32'h0000_00FF, 4'b0000, 1'b1, 1'b1, "single");
        check("single_wb_valid", 64'(bus.wb_valid), 64'd1);
        check("single_wb_addr", 64'(bus.wb_addr), 64'd5);
        check("single_wb_data", 64'(bus.wb_data), 64'hFF);
        check("single_flags", 64'(flags), 64'd0);
        check("single_count", 64'(count), 64'd1);
        wait_drain("single");

        // Back-pressure: two accepted, third refused until a slot frees
        bus.wb_ready = 1'b0;
        accept_op(5'd1, 32'hA1A1_0001, 4'b0000, 1'b1, 1'b0, "bp_a");
        check("bp_in_ready_1", 64'(bus.in_ready), 64'd1);
        check("bp_count_1", 64'(count), 64'd1);
        accept_op(5'd2, 32'hB2B2_0002, 4'b0000, 1'b1, 1'b0, "bp_b");
        check("bp_in_ready_2", 64'(bus.in_ready), 64'd0);
        check("bp_count_2", 64'(count), 64'd2);
        bus.in_rd     = 5'd3;
        bus.in_result = 32'hC3C3_0003;
        bus.in_we     = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_count", 64'(count), 64'd2);
            check("bp_hold_ready", 64'(bus.in_ready), 64'd0);
            check("bp_hold_addr", 64'(bus.wb_addr), 64'd1);
            check("bp_hold_data", 64'(bus.wb_data), 64'hA1A1_0001);
        end
        bus.wb_ready = 1'b1;
        accept_op(5'd3, 32'hC3C3_0003, 4'b0000, 1'b1, 1'b0, "bp_c");
        wait_drain("bp");

        // Push+pop at count=1 keeps occupancy steady
        bus.wb_ready = 1'b1;
        accept_op(5'd8, 32'h0000_0080, 4'b0000, 1'b1, 1'b0, "pp_first");
        check("pp_count_first", 64'(count), 64'd1);
        for (int i = 0; i < 4; i++) begin
            accept_op(5'(9 + i), 32'h0000_0090 + 32'(i), 4'b0000, 1'b1, 1'b0, "pp");
            check("pp_count", 64'(count), 64'd1);
        end
        wait_drain("pp");

        // Sticky overflow set, collision with clear, then a plain clear
        accept_op(5'd0, 32'h0, 4'b0010, 1'b0, 1'b1, "ov");
        check("ov_sticky", 64'(sticky_o), 64'd1);
        check("ov_flags", 64'(flags), 64'b0010);
        check("ov_count", 64'(count), 64'd0);
        clr_sticky = 1'b1;
        accept_op(5'd0, 32'h0, 4'b0110, 1'b0, 1'b1, "collide");
        clr_sticky = 1'b0;
        check("collide_sticky", 64'(sticky_o), 64'd1);
        check("collide_flags", 64'(flags), 64'b0110);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("clr_sticky", 64'(sticky_o), 64'd0);
        accept_op(5'd0, 32'h0, 4'b1111, 1'b0, 1'b0, "noflagwe");
        check("noflagwe_flags", 64'(flags), 64'b0110);
        check("noflagwe_sticky", 64'(sticky_o), 64'd0);

        // Flag-only op does not touch the buffer
        bus.wb_ready = 1'b0;
        accept_op(5'd7, 32'h0000_0077, 4'b0000, 1'b1, 1'b0, "nowe_pre");
        accept_op(5'd0, 32'hDEAD_BEEF, 4'b1000, 1'b0, 1'b1, "nowe");
        check("nowe_count", 64'(count), 64'd1);
        check("nowe_wb_valid", 64'(bus.wb_valid), 64'd1);
        check("nowe_wb_addr", 64'(bus.wb_addr), 64'd7);
        check("nowe_flags", 64'(flags), 64'b1000);
        wait_drain("nowe");

        // Asynchronous reset with a full buffer
        bus.wb_ready = 1'b0;
        accept_op(5'd10, 32'h1010_1010, 4'b0011, 1'b1, 1'b1, "mid_a");
        accept_op(5'd11, 32'h1111_1111, 4'b0101, 1'b1, 1'b1, "mid_b");
        check("mid_count", 64'(count), 64'd2);
        check("mid_sticky", 64'(sticky_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_count", 64'(count), 64'd0);
        check("async_wb_valid", 64'(bus.wb_valid), 64'd0);
        check("async_wb_data", 64'(bus.wb_data), 64'd0);
        check("async_flags", 64'(flags), 64'd0);
        check("async_sticky", 64'(sticky_o), 64'd0);
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
        check("after_rst_count", 64'(count), 64'd0);
        check("after_rst_in_ready", 64'(bus.in_ready), 64'd1);
        accept_op(5'd31, 32'hFFFF_FFFF, 4'b0001, 1'b1, 1'b1, "after_rst");
        check("after_rst_flags", 64'(flags), 64'b0001);
        wait_drain("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
